// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: central stall/flush sequencer for the 5-stage pipeline.
// Owns the dmem and MDU handshakes and the saturating stall/flush counters.
module pipeline_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    input  logic             ex_mdu_op,
    input  logic             mdu_done,
    input  logic             mem_access,
    input  logic             dmem_ack,
    output logic             pc_we,
    output logic             pc_redirect,
    output logic             if_id_we,
    output logic             if_id_flush,
    output logic             id_ex_we,
    output logic             id_ex_flush,
    output logic             ex_mem_we,
    output logic             ex_mem_flush,
    output logic             mem_wb_we,
    output logic             mem_wb_flush,
    output logic             dmem_req,
    output logic             mdu_start,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        D_IDLE,
        D_WAIT,
        D_DONE
    } dstate_t;

    typedef enum logic [1:0] {
        M_IDLE,
        M_BUSY,
        M_DONE
    } mstate_t;

    dstate_t           d_state;
    dstate_t           d_next;
    logic [WCNT_W-1:0] wcnt;
    logic [WCNT_W-1:0] wcnt_next;
    logic              err_set;
    logic              mem_stall;

    mstate_t           m_state;
    mstate_t           m_next;
    logic              start_raw;
    logic              ex_stall;

    logic              load_use;
    logic              branch_fire;

    // dmem state register and wait counter; the error flag is sticky
    always_ff @(posedge clk) begin
        if (rst) begin
            d_state <= D_IDLE;
            wcnt    <= '0;
            mem_err <= 1'b0;
        end else begin
            d_state <= d_next;
            wcnt    <= wcnt_next;
            if (err_set) begin
                mem_err <= 1'b1;
            end
        end
    end

    // dmem handshake: request until ack or timeout, then one release cycle
    always_comb begin
        d_next    = d_state;
        wcnt_next = wcnt;
        err_set   = 1'b0;
        mem_stall = 1'b0;
        unique case (d_state)
            D_IDLE: begin
                if (mem_access) begin
                    mem_stall = 1'b1;
                    d_next    = D_WAIT;
                    wcnt_next = '0;
                end
            end
            D_WAIT: begin
                mem_stall = 1'b1;
                if (dmem_ack) begin
                    d_next = D_DONE;
                end else if (wcnt == WCNT_LAST) begin
                    err_set = 1'b1;
                    d_next  = D_DONE;
                end else begin
                    wcnt_next = wcnt + 1'b1;
                end
            end
            D_DONE: begin
                d_next = D_IDLE;
            end
            default: begin
                d_next = D_IDLE;
            end
        endcase
    end

    // MDU state register
    always_ff @(posedge clk) begin
        if (rst) begin
            m_state <= M_IDLE;
        end else begin
            m_state <= m_next;
        end
    end

    // MDU handshake: start once, wait for done, release for one cycle
    always_comb begin
        m_next    = m_state;
        start_raw = 1'b0;
        unique case (m_state)
            M_IDLE: begin
                if (ex_mdu_op && !mem_stall) begin
                    start_raw = 1'b1;
                    m_next    = M_BUSY;
                end
            end
            M_BUSY: begin
                if (mdu_done) begin
                    m_next = M_DONE;
                end
            end
            M_DONE: begin
                m_next = M_IDLE;
            end
            default: begin
                m_next = M_IDLE;
            end
        endcase
    end

    assign ex_stall = ex_mdu_op && (m_state != M_DONE);

    assign load_use = ex_mem_read
                   && (ex_rd != 5'd0)
                   && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    // priority resolution of stalls, redirects and bubbles; all quiet in reset
    always_comb begin
        pc_we        = 1'b0;
        pc_redirect  = 1'b0;
        if_id_we     = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_we     = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_we    = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_we    = 1'b0;
        mem_wb_flush = 1'b0;
        dmem_req     = 1'b0;
        mdu_start    = 1'b0;
        branch_fire  = 1'b0;
        if (!rst) begin
            dmem_req  = mem_stall;
            mdu_start = start_raw;
            if (mem_stall) begin
                mem_wb_we    = 1'b1;
                mem_wb_flush = 1'b1;
            end else if (ex_stall) begin
                ex_mem_we    = 1'b1;
                ex_mem_flush = 1'b1;
                mem_wb_we    = 1'b1;
            end else if (ex_branch_taken) begin
                branch_fire = 1'b1;
                pc_we       = 1'b1;
                pc_redirect = 1'b1;
                if_id_we    = 1'b1;
                if_id_flush = 1'b1;
                id_ex_we    = 1'b1;
                id_ex_flush = 1'b1;
                ex_mem_we   = 1'b1;
                mem_wb_we   = 1'b1;
            end else if (load_use) begin
                id_ex_we    = 1'b1;
                id_ex_flush = 1'b1;
                ex_mem_we   = 1'b1;
                mem_wb_we   = 1'b1;
            end else begin
                pc_we     = 1'b1;
                if_id_we  = 1'b1;
                id_ex_we  = 1'b1;
                ex_mem_we = 1'b1;
                mem_wb_we = 1'b1;
            end
        end
    end

    // saturating performance counters for frozen-PC cycles and redirects
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_we && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (branch_fire && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: vector table, directed corner sequences and random
// stimulus against a queue-free behavioural model of the sequencer.
module tb_pipeline_ctrl;

    localparam int TIMEOUT = 16;

    localparam logic [11:0] C_NORM = 12'b1010_1010_1000;
    localparam logic [11:0] C_LU   = 12'b0000_1110_1000;
    localparam logic [11:0] C_BR   = 12'b1111_1110_1000;
    localparam logic [11:0] C_MEM  = 12'b0000_0000_1100;
    localparam logic [11:0] C_EXS  = 12'b0000_0011_1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        ex_mem_read, ex_branch_taken, ex_mdu_op;
    logic        mdu_done, mem_access, dmem_ack;

    logic        pc_we, pc_redirect, if_id_we, if_id_flush;
    logic        id_ex_we, id_ex_flush, ex_mem_we, ex_mem_flush;
    logic        mem_wb_we, mem_wb_flush, dmem_req, mdu_start, mem_err;
    logic [31:0] stall_cnt, flush_cnt;

    logic        s_pc_we, s_pc_redirect, s_if_id_we, s_if_id_flush;
    logic        s_id_ex_we, s_id_ex_flush, s_ex_mem_we, s_ex_mem_flush;
    logic        s_mem_wb_we, s_mem_wb_flush, s_dmem_req, s_mdu_start;
    logic        s_mem_err;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    pipeline_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .ex_branch_taken(ex_branch_taken), .ex_mdu_op(ex_mdu_op),
        .mdu_done(mdu_done), .mem_access(mem_access),
        .dmem_ack(dmem_ack),
        .pc_we(pc_we), .pc_redirect(pc_redirect),
        .if_id_we(if_id_we), .if_id_flush(if_id_flush),
        .id_ex_we(id_ex_we), .id_ex_flush(id_ex_flush),
        .ex_mem_we(ex_mem_we), .ex_mem_flush(ex_mem_flush),
        .mem_wb_we(mem_wb_we), .mem_wb_flush(mem_wb_flush),
        .dmem_req(dmem_req), .mdu_start(mdu_start),
        .mem_err(mem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .ex_branch_taken(ex_branch_taken), .ex_mdu_op(ex_mdu_op),
        .mdu_done(mdu_done), .mem_access(mem_access),
        .dmem_ack(dmem_ack),
        .pc_we(s_pc_we), .pc_redirect(s_pc_redirect),
        .if_id_we(s_if_id_we), .if_id_flush(s_if_id_flush),
        .id_ex_we(s_id_ex_we), .id_ex_flush(s_id_ex_flush),
        .ex_mem_we(s_ex_mem_we), .ex_mem_flush(s_ex_mem_flush),
        .mem_wb_we(s_mem_wb_we), .mem_wb_flush(s_mem_wb_flush),
        .dmem_req(s_dmem_req), .mdu_start(s_mdu_start),
        .mem_err(s_mem_err),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    logic [11:0] dut_ctrl, sat_ctrl;
    assign dut_ctrl = {pc_we, pc_redirect, if_id_we, if_id_flush,
                       id_ex_we, id_ex_flush, ex_mem_we, ex_mem_flush,
                       mem_wb_we, mem_wb_flush, dmem_req, mdu_start};
    assign sat_ctrl = {s_pc_we, s_pc_redirect, s_if_id_we, s_if_id_flush,
                       s_id_ex_we, s_id_ex_flush, s_ex_mem_we,
                       s_ex_mem_flush, s_mem_wb_we, s_mem_wb_flush,
                       s_dmem_req, s_mdu_start};

    int total = 0;
    int bad   = 0;

    // reference model: cycles spent requesting (0 = none outstanding),
    // a one-cycle release after completion, and MDU running/finished flags
    int      m_age;
    bit      m_release;
    bit      m_err;
    bit      mdu_run;
    bit      mdu_fin;
    longint  m_stall;
    longint  m_flush;
    logic [11:0] obs;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] model_out();
        logic        ms, es, hz;
        logic [11:0] e;
        if (rst) return 12'd0;
        ms = !m_release && ((m_age > 0) || mem_access);
        es = ex_mdu_op && !mdu_fin;
        hz = ex_mem_read && (ex_rd != 5'd0)
             && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
        if (ms)                   e = C_MEM;
        else if (es)              e = C_EXS;
        else if (ex_branch_taken) e = C_BR;
        else if (hz)              e = C_LU;
        else                      e = C_NORM;
        e[1] = ms;
        e[0] = ex_mdu_op && !mdu_run && !mdu_fin && !ms;
        return e;
    endfunction

    task automatic model_step(input logic [11:0] e);
        if (rst) begin
            m_age = 0; m_release = 0; m_err = 0;
            mdu_run = 0; mdu_fin = 0;
            m_stall = 0; m_flush = 0;
            return;
        end
        if (m_release) m_release = 0;
        else if (m_age == 0) begin
            if (mem_access) m_age = 1;
        end else if (dmem_ack) begin
            m_age = 0; m_release = 1;
        end else if (m_age == TIMEOUT) begin
            m_age = 0; m_release = 1; m_err = 1;
        end else m_age++;
        if (mdu_fin) mdu_fin = 0;
        else if (mdu_run) begin
            if (mdu_done) begin
                mdu_run = 0; mdu_fin = 1;
            end
        end else if (e[0]) mdu_run = 1;
        if (!e[11]) m_stall++;
        if (e[10]) m_flush++;
    endtask

    // inputs are driven just after a rising edge; outputs compared mid-cycle
    task automatic cycle();
        logic [11:0] e;
        #1;
        e   = model_out();
        obs = dut_ctrl;
        check("ctrl", dut_ctrl, e);
        check("sat_ctrl", sat_ctrl, e);
        @(posedge clk);
        model_step(e);
        #1;
        check("mem_err", mem_err, m_err);
        check("stall_cnt", stall_cnt, m_stall);
        check("flush_cnt", flush_cnt, m_flush);
        check("sat_stall", s_stall_cnt, (m_stall > 3) ? 3 : m_stall);
        check("sat_flush", s_flush_cnt, (m_flush > 3) ? 3 : m_flush);
    endtask

    task automatic idle_inputs();
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
        ex_mem_read = 0; ex_branch_taken = 0; ex_mdu_op = 0;
        mdu_done = 0; mem_access = 0; dmem_ack = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        cycle();
        check("rst_outs", obs, 12'd0);
        rst = 0;
    endtask

    typedef struct {
        logic [4:0]  rs1, rs2, rd;
        logic        ld, br;
        logic [11:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[8];
    int   reqs, bub, frz, starts, redir_at;

    initial begin
        tbl[0] = '{5'd1, 5'd2, 5'd3, 1'b0, 1'b0, C_NORM, "plain"};
        tbl[1] = '{5'd1, 5'd5, 5'd5, 1'b1, 1'b0, C_LU,   "lu_rs2"};
        tbl[2] = '{5'd7, 5'd2, 5'd7, 1'b1, 1'b0, C_LU,   "lu_rs1"};
        tbl[3] = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b0, C_NORM, "rd_zero"};
        tbl[4] = '{5'd5, 5'd5, 5'd5, 1'b0, 1'b0, C_NORM, "no_load"};
        tbl[5] = '{5'd4, 5'd6, 5'd5, 1'b1, 1'b0, C_NORM, "no_match"};
        tbl[6] = '{5'd1, 5'd2, 5'd3, 1'b0, 1'b1, C_BR,   "branch"};
        tbl[7] = '{5'd9, 5'd0, 5'd9, 1'b1, 1'b1, C_BR,   "br_lu"};

        m_age = 0; m_release = 0; m_err = 0;
        mdu_run = 0; mdu_fin = 0; m_stall = 0; m_flush = 0;
        obs = 0;

        do_reset();
        for (int i = 0; i < 8; i++) begin
            id_rs1 = tbl[i].rs1; id_rs2 = tbl[i].rs2; ex_rd = tbl[i].rd;
            ex_mem_read = tbl[i].ld; ex_branch_taken = tbl[i].br;
            cycle();
            check(tbl[i].name, obs, tbl[i].exp);
        end
        check("tbl_stall_cnt", stall_cnt, 2);
        check("tbl_flush_cnt", flush_cnt, 2);

        // memory wait: ack on the fourth request cycle
        do_reset();
        mem_access = 1;
        reqs = 0; bub = 0; frz = 0;
        for (int i = 0; i < 4; i++) begin
            dmem_ack = (i == 3);
            cycle();
            reqs += int'(obs[1]);
            bub  += int'(obs[3] && obs[2]);
            frz  += int'(!obs[11] && !obs[9] && !obs[7] && !obs[5]);
        end
        check("mw_req_cycles", reqs, 4);
        check("mw_bubbles", bub, 4);
        check("mw_frozen", frz, 4);
        check("mw_stall_cnt", stall_cnt, 4);
        dmem_ack = 0;
        cycle();
        check("mw_release", obs, C_NORM);
        mem_access = 0;
        cycle();
        check("mw_idle", obs, C_NORM);

        // timeout: no ack at all
        do_reset();
        mem_access = 1;
        reqs = 0;
        for (int i = 0; i < 17; i++) begin
            cycle();
            reqs += int'(obs[1]);
            if (i == 15) check("to_err_early", mem_err, 0);
        end
        check("to_req_cycles", reqs, 17);
        check("to_err_set", mem_err, 1);
        check("to_stall_cnt", stall_cnt, 17);
        mem_access = 0;
        cycle();
        check("to_release", obs, C_NORM);
        cycle();
        check("to_idle", obs, C_NORM);
        check("to_err_sticky", mem_err, 1);

        // MDU op with a taken branch held behind it
        do_reset();
        ex_mdu_op = 1; ex_branch_taken = 1;
        starts = 0; redir_at = -1;
        for (int i = 0; i < 7; i++) begin
            mdu_done = (i == 5);
            cycle();
            starts += int'(obs[0]);
            if (obs[10] && redir_at < 0) redir_at = i;
        end
        check("mdu_starts", starts, 1);
        check("mdu_redirect_cycle", redir_at, 6);
        check("mdu_flush_cnt", flush_cnt, 1);
        idle_inputs();
        cycle();

        // reset in the middle of a memory wait
        do_reset();
        mem_access = 1;
        for (int i = 0; i < 3; i++) cycle();
        rst = 1;
        cycle();
        check("rw_req_in_rst", obs[1], 0);
        check("rw_cnt_cleared", stall_cnt, 0);
        rst = 0; mem_access = 0;
        cycle();
        check("rw_after", obs, C_NORM);

        // random traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst             = ($urandom_range(0, 199) == 0);
            id_rs1          = 5'($urandom_range(0, 3));
            id_rs2          = 5'($urandom_range(0, 3));
            ex_rd           = 5'($urandom_range(0, 3));
            ex_mem_read     = ($urandom_range(0, 99) < 40);
            ex_branch_taken = ($urandom_range(0, 99) < 20);
            ex_mdu_op       = ($urandom_range(0, 99) < 20);
            mdu_done        = ($urandom_range(0, 99) < 25);
            mem_access      = ($urandom_range(0, 99) < 20);
            dmem_ack        = ($urandom_range(0, 99) < 10);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
